// File: rtl/batch_norm_mc_pkg.sv
// rtl/batch_norm_mc_pkg.sv - shared widths, saturation limits and rounding helper for batch_norm_mc
package batch_norm_mc_pkg;

  // Wide enough for any product plus bias while BIT_WIDTH+MULT_BITW stays below 62.
  localparam int MAX_W = 64;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Drops frac fractional bits, rounding half toward +infinity.
  function automatic logic signed [MAX_W-1:0] round_shift(input logic signed [MAX_W-1:0] x,
                                                          input int frac);
    if (frac == 0) return x;
    return ((x >>> (frac - 1)) + 64'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/bn_coef_regs.sv
// rtl/bn_coef_regs.sv - per-channel scale/bias register file
// One write port, one registered read port; every entry resets to identity scale and zero bias.
module bn_coef_regs #(
  parameter int CHANNELS  = 4,
  parameter int ADDR_W    = 2,
  parameter int MULT_BITW = 16,
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITW = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic signed [MULT_BITW-1:0] wmult,
  input  logic signed [BIT_WIDTH-1:0] wbias,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           raddr,
  output logic signed [MULT_BITW-1:0] rmult,
  output logic signed [BIT_WIDTH-1:0] rbias
);

  localparam logic signed [MULT_BITW-1:0] IDENT = MULT_BITW'(1) << FRAC_BITW;

  logic signed [MULT_BITW-1:0] mult_q [CHANNELS];
  logic signed [BIT_WIDTH-1:0] bias_q [CHANNELS];

  // The read samples pre-edge contents, so a same-cycle write is seen only by later reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mult_q[i] <= IDENT;
        bias_q[i] <= '0;
      end
      rmult <= IDENT;
      rbias <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (we && waddr == ADDR_W'(i)) begin
          mult_q[i] <= wmult;
          bias_q[i] <= wbias;
        end
      end
      if (re) begin
        rmult <= mult_q[raddr];
        rbias <= bias_q[raddr];
      end
    end
  end

endmodule

// File: rtl/batch_norm_mc.sv
// rtl/batch_norm_mc.sv - multi-channel fixed-point batch-norm: out = sat(round(x*mult) + bias)
// Three-stage pipeline with a single global stall driven by the output handshake.
module batch_norm_mc
  import batch_norm_mc_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITW = 8,
  parameter int CHANNELS  = 4,
  parameter int MULT_BITW = BIT_WIDTH,
  parameter int RELU      = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              coef_we,
  input  logic [addr_w(CHANNELS)-1:0]       coef_addr,
  input  logic signed [MULT_BITW-1:0]       coef_mult,
  input  logic signed [BIT_WIDTH-1:0]       coef_bias,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_first,
  input  logic signed [BIT_WIDTH-1:0]       in_val,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [BIT_WIDTH-1:0]       out_val,
  output logic [addr_w(CHANNELS)-1:0]       out_ch
);

  localparam int CH_W   = addr_w(CHANNELS);
  localparam int PROD_W = BIT_WIDTH + MULT_BITW;
  localparam logic signed [MAX_W-1:0] SAT_HI = sat_max(BIT_WIDTH);
  localparam logic signed [MAX_W-1:0] SAT_LO = sat_min(BIT_WIDTH);

  logic                        en;
  logic                        accept;
  logic [CH_W-1:0]             ch_cnt;
  logic [CH_W-1:0]             cur_ch;
  logic [CH_W-1:0]             nxt_ch;

  logic                        s1_valid;
  logic signed [BIT_WIDTH-1:0] s1_val;
  logic [CH_W-1:0]             s1_ch;
  logic signed [MULT_BITW-1:0] c_mult;
  logic signed [BIT_WIDTH-1:0] c_bias;

  logic                        s2_valid;
  logic signed [PROD_W-1:0]    s2_prod;
  logic signed [BIT_WIDTH-1:0] s2_bias;
  logic [CH_W-1:0]             s2_ch;

  logic signed [MAX_W-1:0]     prod_ext;
  logic signed [MAX_W-1:0]     bias_ext;
  logic signed [MAX_W-1:0]     rounded;
  logic signed [MAX_W-1:0]     sum;
  logic signed [BIT_WIDTH-1:0] res;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign cur_ch   = in_first ? '0 : ch_cnt;
  assign nxt_ch   = (cur_ch == CH_W'(CHANNELS - 1)) ? '0 : cur_ch + CH_W'(1);

  // Coefficient read port registers alongside S1, indexed by the incoming sample's channel.
  bn_coef_regs #(
    .CHANNELS  (CHANNELS),
    .ADDR_W    (CH_W),
    .MULT_BITW (MULT_BITW),
    .BIT_WIDTH (BIT_WIDTH),
    .FRAC_BITW (FRAC_BITW)
  ) u_coef_regs (
    .clock (clock),
    .reset (reset),
    .we    (coef_we),
    .waddr (coef_addr),
    .wmult (coef_mult),
    .wbias (coef_bias),
    .re    (accept),
    .raddr (cur_ch),
    .rmult (c_mult),
    .rbias (c_bias)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_ch    <= '0;
      ch_cnt   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_val <= in_val;
        s1_ch  <= cur_ch;
        ch_cnt <= nxt_ch;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_bias  <= '0;
      s2_ch    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= $signed({{MULT_BITW{s1_val[BIT_WIDTH-1]}}, s1_val})
                * $signed({{BIT_WIDTH{c_mult[MULT_BITW-1]}}, c_mult});
      s2_bias  <= c_bias;
      s2_ch    <= s1_ch;
    end
  end

  always_comb begin
    prod_ext = {{(MAX_W - PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
    bias_ext = {{(MAX_W - BIT_WIDTH){s2_bias[BIT_WIDTH-1]}}, s2_bias};
    rounded  = round_shift(prod_ext, FRAC_BITW);
    sum      = rounded + bias_ext;
    if (sum > SAT_HI)      res = SAT_HI[BIT_WIDTH-1:0];
    else if (sum < SAT_LO) res = SAT_LO[BIT_WIDTH-1:0];
    else                   res = sum[BIT_WIDTH-1:0];
    if (RELU != 0 && res[BIT_WIDTH-1]) res = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_val   <= '0;
      out_ch    <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_val   <= res;
      out_ch    <= s2_ch;
    end
  end

endmodule
